// File: rtl/apb_gpio_debounce_pkg.sv
// Shared definitions for the APB GPIO input conditioner: register map and reset values.
package apb_gpio_pkg;

    typedef enum logic [1:0] {
        REG_DBEN     = 2'd0,
        REG_PRESCALE = 2'd1,
        REG_THRESH   = 2'd2,
        REG_STATUS   = 2'd3
    } reg_sel_e;

    localparam logic [11:0] OFF_DBEN     = 12'h000;
    localparam logic [11:0] OFF_PRESCALE = 12'h004;
    localparam logic [11:0] OFF_THRESH   = 12'h008;
    localparam logic [11:0] OFF_STATUS   = 12'h00C;

    localparam logic [31:0] DBEN_RST     = 32'h0000_0000;
    localparam logic [31:0] PRESCALE_RST = 32'h0000_0000;
    localparam logic [31:0] THRESH_RST   = 32'h0000_0000;

endpackage

// File: rtl/apb_gpio_debounce_cell.sv
// One pin of the conditioner: filtered-value register, stability counter and bypass mux.
module gpio_debounce_cell
    import apb_gpio_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 sync_in,
    input  logic                 tick,
    input  logic [CNT_WIDTH-1:0] thresh,
    input  logic                 en,
    output logic                 gpio_filt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 filt_r;
    logic [CNT_WIDTH-1:0] cnt_r;

    // Filter state; bypassed pins keep filt_r tracking sync_in so enabling never glitches.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            filt_r <= 1'b0;
            cnt_r  <= CNT_ZERO;
        end else if (!en) begin
            filt_r <= sync_in;
            cnt_r  <= CNT_ZERO;
        end else if (sync_in == filt_r) begin
            cnt_r  <= CNT_ZERO;
        end else if (tick && (cnt_r >= thresh)) begin
            filt_r <= sync_in;
            cnt_r  <= CNT_ZERO;
        end else if (tick) begin
            cnt_r  <= cnt_r + CNT_ONE;
        end
    end

    // Output select between filtered and synchronised value.
    always_comb begin
        if (en) begin
            gpio_filt = filt_r;
        end else begin
            gpio_filt = sync_in;
        end
    end

endmodule

// File: rtl/apb_gpio_debounce.sv
// APB-configured per-pin input conditioner: pad synchroniser, shared sample prescaler and
// per-pin debounce cells feeding the GPIO block's gpio_in.
module apb_gpio_debounce
    import apb_gpio_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NPINS          = 32,
    parameter int CNT_WIDTH      = 8,
    parameter int PRE_WIDTH      = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NPINS-1:0]          pad_in,
    output logic [NPINS-1:0]          gpio_filt
);

    localparam logic [PRE_WIDTH-1:0] PRE_ZERO = {PRE_WIDTH{1'b0}};
    localparam logic [PRE_WIDTH-1:0] PRE_ONE  = {{(PRE_WIDTH-1){1'b0}}, 1'b1};

    reg_sel_e             sel_s;
    logic                 wr_s;
    logic                 pre_wr_s;
    logic                 tick_s;
    logic                 unused_s;
    logic [31:0]          prdata_s;
    logic [NPINS-1:0]     dben_r;
    logic [PRE_WIDTH-1:0] prescale_r;
    logic [CNT_WIDTH-1:0] thresh_r;
    logic [NPINS-1:0]     sync0_r;
    logic [NPINS-1:0]     sync1_r;
    logic [PRE_WIDTH-1:0] pcnt_r;

    assign sel_s    = reg_sel_e'(PADDR[3:2]);
    assign unused_s = ^{PADDR, PWDATA};
    assign PREADY   = 1'b1;
    assign PSLVERR  = 1'b0;
    assign PRDATA   = prdata_s;

    // Write strobe and sample tick; a PRESCALE write suppresses the tick of its own cycle.
    always_comb begin
        wr_s     = PSEL && PENABLE && PWRITE;
        pre_wr_s = wr_s && (sel_s == REG_PRESCALE);
        tick_s   = (pcnt_r == prescale_r) && !pre_wr_s;
    end

    // Configuration registers; STATUS is read-only.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dben_r     <= DBEN_RST[NPINS-1:0];
            prescale_r <= PRESCALE_RST[PRE_WIDTH-1:0];
            thresh_r   <= THRESH_RST[CNT_WIDTH-1:0];
        end else if (wr_s) begin
            case (sel_s)
                REG_DBEN:     dben_r     <= PWDATA[NPINS-1:0];
                REG_PRESCALE: prescale_r <= PWDATA[PRE_WIDTH-1:0];
                REG_THRESH:   thresh_r   <= PWDATA[CNT_WIDTH-1:0];
                REG_STATUS:   ;
                default:      ;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous pads.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync0_r <= {NPINS{1'b0}};
            sync1_r <= {NPINS{1'b0}};
        end else begin
            sync0_r <= pad_in;
            sync1_r <= sync0_r;
        end
    end

    // Sample prescaler counting 0..PRESCALE.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pcnt_r <= PRE_ZERO;
        end else if (pre_wr_s || tick_s) begin
            pcnt_r <= PRE_ZERO;
        end else begin
            pcnt_r <= pcnt_r + PRE_ONE;
        end
    end

    // Read mux, zero-extended.
    always_comb begin
        prdata_s = 32'h0000_0000;
        case (sel_s)
            REG_DBEN:     prdata_s[NPINS-1:0]     = dben_r;
            REG_PRESCALE: prdata_s[PRE_WIDTH-1:0] = prescale_r;
            REG_THRESH:   prdata_s[CNT_WIDTH-1:0] = thresh_r;
            REG_STATUS:   prdata_s[NPINS-1:0]     = sync1_r;
            default:      prdata_s                = 32'h0000_0000;
        endcase
    end

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        gpio_debounce_cell #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cell (
            .HCLK      (HCLK),
            .HRESET    (HRESET),
            .sync_in   (sync1_r[i]),
            .tick      (tick_s),
            .thresh    (thresh_r),
            .en        (dben_r[i]),
            .gpio_filt (gpio_filt[i])
        );
    end

endmodule
